// File: rtl/ysyx_040066_cache_axi_bridge.sv
// ysyx_040066_cache_axi_bridge
// Memory-side responder for the cache line-refill interface. One cache-line
// read (refill) or write (write-back) is run as a single AXI4 INCR burst of
// 64-bit beats, then completion is pulsed back to the cache for one cycle.
// Only one transaction is outstanding at a time; write requests win over
// read requests so a dirty victim leaves before its replacement arrives.
//
// Optional build macro YSYX_040066_AXI_CHECK_EN: when defined, an rlast that
// disagrees with the beat counter flags rd_error (completion still follows
// the beat counter). When undefined, rlast is ignored.
module ysyx_040066_cache_axi_bridge #(
  parameter int LINE_LEN = 512
) (
  input  logic                clk,
  input  logic                rst,       // asynchronous, active-low
  // cache side
  input  logic [31:0]         addr,
  input  logic                rd_req,
  output logic                rd_ready,
  output logic                rd_error,
  output logic [LINE_LEN-1:0] rd_data,
  input  logic                wr_req,
  input  logic [LINE_LEN-1:0] wr_data,
  output logic                wr_ready,
  output logic                wr_error,
  // AXI read address / data
  output logic [31:0]         araddr,
  output logic                arvalid,
  input  logic                arready,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic [63:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI write address / data / response
  output logic [31:0]         awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [63:0]         wdata,
  output logic [7:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int BEATS = LINE_LEN / 64;
  localparam int OFF   = $clog2(LINE_LEN / 8);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_AR   = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_AW   = 3'd3;
  localparam logic [2:0] WR_DATA = 3'd4;
  localparam logic [2:0] WR_RESP = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       beat_q, beat_d;
  logic                err_q, err_d;
  logic                op_wr_q, op_wr_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_LEN-1:0] rd_data_q, rd_data_d;
  logic                last_beat;

  assign last_beat = (beat_q == LAST_BEAT);

  // Next-state, beat counter, sticky error and refill-line assembly.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the value.
    state_d   = state_q;
    beat_d    = beat_q;
    err_d     = err_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          op_wr_d = 1'b1;
          addr_d  = {addr[31:OFF], {OFF{1'b0}}};
          state_d = WR_AW;
        end else if (rd_req) begin
          op_wr_d = 1'b0;
          addr_d  = {addr[31:OFF], {OFF{1'b0}}};
          state_d = RD_AR;
        end
      end
      RD_AR: if (arready) state_d = RD_DATA;
      RD_DATA: begin
        if (rvalid) begin
          rd_data_d[64*beat_q +: 64] = rdata;
          beat_d = beat_q + CW'(1);
          if (rresp != 2'b00) err_d = 1'b1;
`ifdef YSYX_040066_AXI_CHECK_EN
          if (rlast != last_beat) err_d = 1'b1;
`endif
          if (last_beat) state_d = DONE;
        end
      end
      WR_AW: if (awready) state_d = WR_DATA;
      WR_DATA: begin
        if (wready) begin
          beat_d = beat_q + CW'(1);
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          if (bresp != 2'b00) err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        beat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      err_q     <= 1'b0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      // NOTE: the line buffer is a plain register (not a RAM) and is reset
      // because rd_data is a visible output that must read zero after reset.
      rd_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Handshake and completion outputs decoded from state.
  assign arvalid  = (state_q == RD_AR);
  assign rready   = (state_q == RD_DATA);
  assign awvalid  = (state_q == WR_AW);
  assign wvalid   = (state_q == WR_DATA);
  assign bready   = (state_q == WR_RESP);
  assign wdata    = wvalid ? wr_data[64*beat_q +: 64] : 64'd0;
  assign wlast    = wvalid && last_beat;
  assign rd_ready = (state_q == DONE) && !op_wr_q;
  assign wr_ready = (state_q == DONE) && op_wr_q;
  assign rd_error = rd_ready && err_q;
  assign wr_error = wr_ready && err_q;
  assign rd_data  = rd_data_q;
  assign araddr   = addr_q;
  assign awaddr   = addr_q;

  // Fixed burst shape: full line, 8-byte beats, incrementing, all lanes.
  assign arlen    = 8'(BEATS - 1);
  assign awlen    = 8'(BEATS - 1);
  assign arsize   = 3'd3;
  assign awsize   = 3'd3;
  assign arburst  = 2'b01;
  assign awburst  = 2'b01;
  assign wstrb    = 8'hFF;

  // Line offset bits are dropped by alignment.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[OFF-1:0];
`ifndef YSYX_040066_AXI_CHECK_EN
  logic unused_rlast;
  assign unused_rlast = rlast;
`endif

endmodule

// File: tb/tb_ysyx_040066_cache_axi_bridge.sv
// Directed bench for ysyx_040066_cache_axi_bridge. The bench acts as the
// cache and as a simple AXI slave; inputs change and outputs are sampled on
// the falling clock edge.
module tb_ysyx_040066_cache_axi_bridge;

  localparam int LINE_LEN = 512;
  localparam int BEATS    = LINE_LEN / 64;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [31:0]         addr = '0;
  logic                rd_req = 1'b0, wr_req = 1'b0;
  logic [LINE_LEN-1:0] wr_data = '0;
  logic                rd_ready, rd_error, wr_ready, wr_error;
  logic [LINE_LEN-1:0] rd_data;
  logic [31:0]         araddr, awaddr;
  logic                arvalid, arready = 1'b0;
  logic [7:0]          arlen, awlen, wstrb;
  logic [2:0]          arsize, awsize;
  logic [1:0]          arburst, awburst;
  logic [63:0]         rdata = '0, wdata;
  logic [1:0]          rresp = '0, bresp = '0;
  logic                rlast = 1'b0, rvalid = 1'b0, rready;
  logic                awvalid, awready = 1'b0;
  logic                wlast, wvalid, wready = 1'b0;
  logic                bvalid = 1'b0, bready;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_040066_cache_axi_bridge #(.LINE_LEN(LINE_LEN)) dut (
    .clk(clk), .rst(rst), .addr(addr),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_error(rd_error), .rd_data(rd_data),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ready(wr_ready), .wr_error(wr_error),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_LEN-1:0] obs,
                       input logic [LINE_LEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One line read. Beat i returns seed+i; err_beat gets SLVERR, rlast is
  // raised on last_beat only. stall adds AR and R wait states.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [63:0] seed,
                         input bit stall, input int err_beat, input int last_beat,
                         input logic exp_err, input int exp_cycle);
    int cyc;
    int k = 0;
    logic [LINE_LEN-1:0] exp_line;
    logic [31:0] exp_addr;
    for (int i = 0; i < BEATS; i++) exp_line[64*i +: 64] = seed + 64'(i);
    exp_addr = {a[31:6], 6'b0};
    addr = a; rd_req = 1'b1; arready = !stall;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (rd_ready === 1'b1) break;
      if (cyc == 1) begin
        check({tag, ".arvalid_c1"}, arvalid, 1'b1);
        check({tag, ".awvalid_c1"}, awvalid, 1'b0);
        check({tag, ".araddr"}, araddr, exp_addr);
      end
      if (stall && cyc == 2) check({tag, ".arvalid_held"}, arvalid, 1'b1);
      if (stall) arready = (cyc >= 2);
      if (rready === 1'b1) begin
        rvalid = stall ? (cyc % 2 == 0) : 1'b1;
        if (rvalid) begin
          rdata = seed + 64'(k);
          rresp = (k == err_beat) ? 2'b10 : 2'b00;
          rlast = (k == last_beat);
          k++;
        end
      end else begin
        rvalid = 1'b0;
      end
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
    check({tag, ".rd_ready"}, rd_ready, 1'b1);
    if (exp_cycle >= 0) check({tag, ".rd_ready_cycle"}, cyc, exp_cycle);
    check({tag, ".rd_error"}, rd_error, exp_err);
    check({tag, ".beats"}, k, BEATS);
    check({tag, ".rd_data"}, rd_data, exp_line);
    rd_req = 1'b0;
  endtask

  // One line write-back. stall toggles wready and delays AW and B.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [LINE_LEN-1:0] line,
                          input bit stall, input logic [1:0] br, input logic exp_err,
                          input int exp_cycle);
    int cyc;
    int j = 0;
    int nb = 0;
    int tb_b = -10;
    logic [LINE_LEN-1:0] cap = '0;
    logic [BEATS-1:0] lastv = '0;
    addr = a; wr_data = line; wr_req = 1'b1; awready = !stall;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (wr_ready === 1'b1) break;
      if (cyc == 1) begin
        check({tag, ".awvalid_c1"}, awvalid, 1'b1);
        check({tag, ".arvalid_c1"}, arvalid, 1'b0);
        check({tag, ".awaddr"}, awaddr, {a[31:6], 6'b0});
      end
      if (stall) awready = (cyc >= 2);
      if (wvalid === 1'b1) begin
        wready = stall ? (cyc % 2 == 1) : 1'b1;
        if (wready && j < BEATS) begin
          cap[64*j +: 64] = wdata;
          lastv[j] = wlast;
          j++;
        end
      end else begin
        wready = 1'b0;
      end
      if (bready === 1'b1) begin
        nb++;
        bvalid = !stall || nb >= 2;
        bresp  = br;
        if (bvalid) tb_b = cyc;
      end else begin
        bvalid = 1'b0;
      end
    end
    wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; awready = 1'b0;
    check({tag, ".wr_ready"}, wr_ready, 1'b1);
    check({tag, ".wr_ready_after_b"}, cyc, tb_b + 1);
    if (exp_cycle >= 0) check({tag, ".wr_ready_cycle"}, cyc, exp_cycle);
    check({tag, ".wr_error"}, wr_error, exp_err);
    check({tag, ".rd_ready_quiet"}, rd_ready, 1'b0);
    check({tag, ".wdata_line"}, cap, line);
    check({tag, ".wlast_pattern"}, lastv, {1'b1, {(BEATS-1){1'b0}}});
    wr_req = 1'b0;
  endtask

  logic [LINE_LEN-1:0] line_a, line_b;
  logic exp_chk_err;

  initial begin
    for (int i = 0; i < BEATS; i++) begin
      line_a[64*i +: 64] = 64'hA5A5_0000_0000_0000 | 64'(i * 17 + 1);
      line_b[64*i +: 64] = 64'h1234_5678_0000_0000 + 64'(i << 8);
    end

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst.ctrl", {arvalid, rready, awvalid, wvalid, wlast, bready,
                       rd_ready, wr_ready, rd_error, wr_error}, 10'b0);
    check("rst.wdata", wdata, 64'd0);
    check("rst.addrs", {araddr, awaddr}, 64'd0);
    check("rst.rd_data", rd_data, '0);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait read.
    do_read("rd0", 32'h8000_1234, 64'd0, 1'b0, -1, 7, 1'b0, 10);
    check("rd0.araddr_val", araddr, 32'h8000_1200);
    check("rd0.beat0", rd_data[63:0], 64'd0);
    check("rd0.beat7", rd_data[511:448], 64'd7);
    @(negedge clk);
    check("rd0.pulse_low", rd_ready, 1'b0);

    // Best-case write, then write with stalls.
    do_write("wr0", 32'h4000_0040, line_a, 1'b0, 2'b00, 1'b0, 11);
    @(negedge clk);
    check("wr0.pulse_low", wr_ready, 1'b0);
    do_write("wr1", 32'h4000_00BF, line_b, 1'b1, 2'b00, 1'b0, -1);
    @(negedge clk);

    // Simultaneous requests: write goes first, read follows two cycles later.
    rd_req = 1'b1;
    do_write("both.wr", 32'h9000_0080, line_a, 1'b0, 2'b00, 1'b0, 11);
    @(negedge clk);
    check("both.gap_arvalid", arvalid, 1'b0);
    check("both.gap_wr_ready", wr_ready, 1'b0);
    do_read("both.rd", 32'h9000_0080, 64'h100, 1'b0, -1, 7, 1'b0, 10);
    @(negedge clk);

    // Write with SLVERR response.
    do_write("wrerr", 32'h4000_1000, line_b, 1'b0, 2'b10, 1'b1, 11);
    @(negedge clk);

    // SLVERR on beat 3, then a clean read clears the error.
    do_read("rderr", 32'h2000_0000, 64'h200, 1'b1, 3, 7, 1'b1, -1);
    @(negedge clk);
    do_read("rdclean", 32'h2000_0040, 64'h300, 1'b0, -1, 7, 1'b0, 10);
    @(negedge clk);

    // Early rlast on beat 5 (and none on beat 7).
`ifdef YSYX_040066_AXI_CHECK_EN
    exp_chk_err = 1'b1;
`else
    exp_chk_err = 1'b0;
`endif
    do_read("rlast5", 32'h3000_0000, 64'h400, 1'b0, -1, 5, exp_chk_err, 10);
    @(negedge clk);

    // Reset asserted during beat 4 of a read.
    addr = 32'h5000_0000; rd_req = 1'b1; arready = 1'b1;
    begin
      int k = 0;
      for (int c = 1; c <= 30 && k < 4; c++) begin
        @(negedge clk);
        if (rready === 1'b1) begin
          rvalid = 1'b1; rdata = 64'h500 + 64'(k); rresp = 2'b00; rlast = 1'b0;
          k++;
        end
      end
      check("rstmid.beats_before", k, 4);
    end
    @(posedge clk);
    #2;
    check("rstmid.beat3_stored", rd_data[255:192], 64'h503);
    check("rstmid.rready_beat4", rready, 1'b1);
    rdata = 64'h504;
    rst = 1'b0;
    #1;
    check("rstmid.ctrl", {arvalid, rready, awvalid, wvalid, wlast, bready,
                          rd_ready, wr_ready, rd_error, wr_error}, 10'b0);
    check("rstmid.rd_data", rd_data, '0);
    check("rstmid.addrs", {araddr, awaddr}, 64'd0);
    @(negedge clk);
    rvalid = 1'b0; rd_req = 1'b0; arready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid.idle", {arvalid, rready, rd_ready}, 3'b0);
    do_read("rstmid.next", 32'h5000_0000, 64'h600, 1'b0, -1, 7, 1'b0, 10);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_040066_cache_axi_bridge.md
# ysyx_040066_cache_axi_bridge
Memory-side responder for the data/instruction cache line-refill interface: accepts one cache-line read (refill) or write (write-back) request, runs it as a single AXI4 INCR burst of 64-bit beats, and returns the whole line or its completion status to the cache. Sits between each cache top and the AXI arbiter; one transaction is outstanding at a time.
## Interface
- LINE_LEN, 512, line width in bits; multiple of 64; BEATS = LINE_LEN/64, OFF = log2(LINE_LEN/8)
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- addr  in  32  line address from cache, held stable while rd_req/wr_req is high
- rd_req  in  1  line read request, level, held until rd_ready
- rd_ready  out  1  one-cycle pulse: read done, rd_data/rd_error valid
- rd_error  out  1  any beat returned non-OKAY resp, or protocol error; valid with rd_ready
- rd_data  out  LINE_LEN  refilled line; beat i at [64*i +: 64]
- wr_req  in  1  line write request, level, held until wr_ready
- wr_data  in  LINE_LEN  line to write back, held stable while wr_req high
- wr_ready  out  1  one-cycle pulse: write done, wr_error valid
- wr_error  out  1  bresp non-OKAY; valid with wr_ready
- araddr  out  32  {addr[31:OFF], OFF'b0}
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  64  R data
- rresp  in  2  R response
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready
- awaddr  out  32  {addr[31:OFF], OFF'b0}
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wdata  out  64  wr_data[64*beat +: 64]
- wlast  out  1  high on beat BEATS-1
- wvalid  out  1  W valid
- wready  in  1  W ready
- bresp  in  2  B response
- bvalid  in  1  B valid
- bready  out  1  B ready
- arlen/awlen = BEATS-1, size = 3, burst = INCR, wstrb = 8'hFF are tied at the top level.
## Operation
- FSM states: IDLE, RD_AR, RD_DATA, WR_AW, WR_DATA, WR_RESP, DONE.
- IDLE: wr_req has priority over rd_req (dirty victim leaves before refill). Sampling latches line-aligned addr into araddr/awaddr; go RD_AR or WR_AW.
- RD_AR: arvalid=1 until arready; then RD_DATA. RD_DATA: rready=1; each rvalid&rready writes rdata to rd_data beat slot, beat counter (log2 BEATS bits) increments; rresp!=0 sets sticky error. Handshake on beat BEATS-1 -> DONE.
- WR_AW: awvalid=1 until awready; then WR_DATA. WR_DATA: wvalid=1, wdata/wlast from beat counter; advance on wready; beat BEATS-1 handshake -> WR_RESP. WR_RESP: bready=1; on bvalid capture bresp!=0 -> DONE.
- DONE (1 cycle): pulse rd_ready or wr_ready with error; requests ignored; then IDLE. Sticky error and beat counter clear on leaving DONE.
- AXI valids never drop before handshake; addresses/wdata stable while valid.
## Timing
- Reset: all outputs 0 (valids, readies, pulses, errors, rd_data, addresses); state IDLE. Reset mid-burst abandons the transaction immediately.
- Request seen in IDLE at cycle 0 -> arvalid/awvalid high cycle 1.
- Final R or B handshake at cycle T -> rd_ready/wr_ready high exactly cycle T+1, low T+2; new request accepted no earlier than T+2.
- Best-case read (arready and rvalid always high): rd_ready at cycle BEATS+2. Best-case write: wr_ready at BEATS+3.
- rd_data holds the last line until the next read overwrites it.
## Configuration
- YSYX_040066_AXI_CHECK_EN defined: rlast high on a beat other than BEATS-1, or low on beat BEATS-1, sets rd_error; completion still by beat counter. Undefined: rlast ignored, rd_error reflects rresp only.
## Test plan
- Read, zero wait: rd_req, addr 0x8000_1234 -> araddr 0x8000_1200, 8 beats 0..7 -> rd_ready at cycle 10, rd_data[63:0]=0, [511:448]=7, rd_error=0.
- Write with stalls: wr_req, wready toggling 1/0 -> 8 wdata beats in order, wlast only on beat 7, bresp=0 -> wr_ready one cycle after bvalid, wr_error=0.
- Simultaneous rd_req and wr_req in IDLE -> AW issued first; after wr_ready, AR issued no earlier than two cycles later.
- rresp=SLVERR on beat 3 -> all 8 beats consumed, rd_error=1 with rd_ready; next clean read rd_error=0.
- With YSYX_040066_AXI_CHECK_EN: rlast on beat 5 -> rd_error=1; without: rd_error=0.
- rst low during RD_DATA beat 4 -> all outputs 0 in same cycle, IDLE after release, next read completes correctly.
